// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM,
// and presents registered instructions to the control unit with valid/stall.
module instr_fetch_unit #(
  parameter int unsigned           PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [15:0]         instr,
  output logic [3:0]          opcode,
  output logic [3:0]          FnCode,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                halted,
  output logic [15:0]         instr_count
);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [15:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic [15:0]         count_q, count_d;

  logic accept;
  logic is_halt;
  logic take_branch;

  assign accept      = valid_q & ~stall;
  assign is_halt     = (instr_q[15:12] == HALT_OPCODE);
  assign take_branch = accept & branch_taken & ~is_halt;

  // Replaying pend_pc while stalled keeps the in-flight ROM word on imem_data.
  always_comb begin
    if (state_q == S_HALTED)      imem_addr = pc_q;
    else if (take_branch)         imem_addr = branch_target;
    else if (stall && valid_q)    imem_addr = pend_pc_q;
    else                          imem_addr = pc_q;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pc_out_d  = pc_out_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    count_d   = accept ? count_q + 16'd1 : count_q;

    unique case (state_q)
      S_FILL: begin
        pend_pc_d = imem_addr;
        pc_d      = imem_addr + PC_WIDTH'(1);
        valid_d   = 1'b0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (accept && is_halt) begin
          state_d  = S_HALTED;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (valid_q && stall) begin
          // hold everything
        end else if (take_branch) begin
          valid_d   = 1'b0;
          pend_pc_d = imem_addr;
          pc_d      = imem_addr + PC_WIDTH'(1);
        end else begin
          instr_d   = imem_data;
          pc_out_d  = pend_pc_q;
          valid_d   = 1'b1;
          pend_pc_d = imem_addr;
          pc_d      = imem_addr + PC_WIDTH'(1);
        end
      end
      S_HALTED: begin
        valid_d = 1'b0;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      pc_out_q  <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pc_out_q  <= pc_out_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign instr       = instr_q;
  assign opcode      = instr_q[15:12];
  assign FnCode      = instr_q[3:0];
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous ROM model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  FnCode;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] rom [256];
  int unsigned checks = 0;
  int unsigned errors = 0;

  instr_fetch_unit #(
    .PC_WIDTH(8),
    .RESET_PC(8'h00),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instr(instr),
    .opcode(opcode),
    .FnCode(FnCode),
    .instr_valid(instr_valid),
    .pc_out(pc_out),
    .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [7:0] pc,
                              input logic [15:0] word, input logic [15:0] cnt);
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".pc"},    32'(pc_out), 32'(pc));
    check({tag, ".instr"}, 32'(instr), 32'(word));
    check({tag, ".count"}, 32'(instr_count), 32'(cnt));
  endtask

  task automatic expect_reset(input string tag);
    check({tag, ".instr"},  32'(instr), 32'd0);
    check({tag, ".opcode"}, 32'(opcode), 32'd0);
    check({tag, ".fn"},     32'(FnCode), 32'd0);
    check({tag, ".valid"},  32'(instr_valid), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
    check({tag, ".pc"},     32'(pc_out), 32'd0);
    check({tag, ".count"},  32'(instr_count), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'h20, 8'(i)};
    rom[0] = 16'h0123;
    rom[1] = 16'h0003;
    rom[2] = 16'h3456;
    rom[3] = 16'h4A07;
    rom[4] = 16'hF000;

    // Reset values, then sequential fetch into the halt word
    tick(); tick();
    expect_reset("rst0");
    rst = 1'b0;                       // cycle 0
    tick();
    check("c1.valid", 32'(instr_valid), 32'd0);
    tick();
    expect_instr("seq0", 8'h00, 16'h0123, 16'd0);
    check("seq0.opcode", 32'(opcode), 32'd0);
    check("seq0.fn", 32'(FnCode), 32'd3);
    tick();
    expect_instr("seq1", 8'h01, 16'h0003, 16'd1);
    check("seq1.fn", 32'(FnCode), 32'd3);
    tick();
    expect_instr("seq2", 8'h02, 16'h3456, 16'd2);
    check("seq2.opcode", 32'(opcode), 32'd3);
    tick();
    expect_instr("seq3", 8'h03, 16'h4A07, 16'd3);
    check("seq3.opcode", 32'(opcode), 32'd4);
    tick();
    expect_instr("seq4", 8'h04, 16'hF000, 16'd4);
    check("seq4.halted", 32'(halted), 32'd0);

    // Halt: pc frozen at 6 (pend_pc 5, pc 6 when the halt word was presented)
    branch_taken = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.count", 32'(instr_count), 32'd5);
    for (int i = 0; i < 20; i++) begin
      check("halt.valid", 32'(instr_valid), 32'd0);
      check("halt.addr", 32'(imem_addr), 32'h06);
      tick();
    end
    check("halt.hold", 32'(halted), 32'd1);

    // Restart from ROM[0]
    rst = 1'b1;
    tick();
    expect_reset("rst1");
    rst = 1'b0;
    tick(); tick();
    expect_instr("re0", 8'h00, 16'h0123, 16'd0);
    tick();
    expect_instr("re1", 8'h01, 16'h0003, 16'd1);

    // Stall three cycles with a branch request that must be ignored
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_instr("stall", 8'h01, 16'h0003, 16'd1);
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    tick();
    expect_instr("post_stall", 8'h02, 16'h3456, 16'd2);

    // Taken branch to 0x40: one bubble
    branch_taken = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    check("br.bubble", 32'(instr_valid), 32'd0);
    check("br.count", 32'(instr_count), 32'd3);
    tick();
    expect_instr("br40", 8'h40, 16'h2040, 16'd3);
    tick();
    expect_instr("br41", 8'h41, 16'h2041, 16'd4);

    // Wrap through 0xFF
    branch_taken = 1'b1;
    branch_target = 8'hFE;
    tick();
    branch_taken = 1'b0;
    check("wrap.bubble", 32'(instr_valid), 32'd0);
    tick();
    expect_instr("wrapFE", 8'hFE, 16'h20FE, 16'd5);
    tick();
    expect_instr("wrapFF", 8'hFF, 16'h20FF, 16'd6);
    tick();
    expect_instr("wrap00", 8'h00, 16'h0123, 16'd7);
    tick();
    expect_instr("wrap01", 8'h01, 16'h0003, 16'd8);

    // Reset in the middle of a stall
    stall = 1'b1;
    tick();
    expect_instr("ms.hold", 8'h01, 16'h0003, 16'd8);
    rst = 1'b1;
    tick();
    expect_reset("rst_mid_stall");
    rst = 1'b0;
    stall = 1'b0;
    tick(); tick();
    expect_instr("ms.restart", 8'h00, 16'h0123, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the 16-bit RISC processor. It owns the program counter, issues addresses to the synchronous instruction ROM, and registers the returned word. It presents `opcode`/`FnCode` and the full instruction to `ControlUnit` with a valid/stall handshake. It also redirects on taken branches and stops permanently on the halt opcode.

## Interface
- `PC_WIDTH`, 8, program-counter and ROM address width.
- `RESET_PC`, 0, first fetch address after reset.
- `HALT_OPCODE`, 4'hF, opcode that stops fetching.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `imem_addr`  out  PC_WIDTH  ROM address. The ROM samples it at the rising edge; data appears on `imem_data` the next cycle.
- `imem_data`  in  16  ROM read data.
- `stall`  in  1  downstream not accepting; hold the presented instruction.
- `branch_taken`  in  1  redirect request for the instruction currently presented.
- `branch_target`  in  PC_WIDTH  redirect address.
- `instr`  out  16  registered instruction word.
- `opcode`  out  4  `instr[15:12]`.
- `FnCode`  out  4  `instr[3:0]`, the function code for opcode 0.
- `instr_valid`  out  1  `instr`/`opcode`/`FnCode`/`pc_out` are meaningful.
- `pc_out`  out  PC_WIDTH  address of the presented instruction.
- `halted`  out  1  halt reached.
- `instr_count`  out  16  number of instructions accepted.

## Operation
- Internal registers: `pc` (next fetch address) and `pend_pc` (address whose data is on `imem_data`).
- State machine has three states:
  - FILL: `imem_data` not yet meaningful.
  - RUN: `imem_data` holds `mem[pend_pc]`.
  - HALTED: fetching stopped.
- Reset: state FILL, `pc`=`RESET_PC`, `pend_pc`=`RESET_PC`. Output reset values:
  - `instr`=0, `opcode`=0, `FnCode`=0.
  - `instr_valid`=0, `halted`=0.
  - `pc_out`=`RESET_PC`, `instr_count`=0.
- "Accept" means `instr_valid`=1 and `stall`=0 at a rising edge. Each accept increments `instr_count`, which wraps 0xFFFF→0.
- `imem_addr` (combinational), by priority:
  1. In HALTED: `pc`.
  2. If accept with `branch_taken`=1 and the presented opcode is not `HALT_OPCODE`: `branch_target`.
  3. If `stall`=1 with `instr_valid`=1: `pend_pc`. This replays the in-flight read so ROM data is not lost.
  4. Otherwise: `pc`.
- FILL: at the edge, `pend_pc`←`imem_addr`, `pc`←`imem_addr`+1, go to RUN. `instr_valid`←0.
- RUN, when not stalled: at the edge, `instr`←`imem_data`, `pc_out`←`pend_pc`, `instr_valid`←1. Then `pend_pc`←`imem_addr`, `pc`←`imem_addr`+1.
- RUN with `stall`=1 and `instr_valid`=1: `instr`, `pc_out`, `instr_valid`, `pc` and `pend_pc` all hold.
- Taken branch: on accept with `branch_taken`=1, at the edge:
  - `instr_valid`←0, flushing the word on `imem_data`.
  - `pend_pc`←`branch_target`, `pc`←`branch_target`+1.
  - State stays RUN.
  - `branch_taken` is ignored while `stall`=1 or `instr_valid`=0.
- Halt: on accept of an instruction whose opcode is `HALT_OPCODE`, at the edge:
  - Go to HALTED; `instr_valid`←0, `halted`←1.
  - `pc` and `pend_pc` freeze.
  - Halt beats a simultaneous `branch_taken`.
- HALTED: all outputs hold. Only `rst` exits.
- `pc` arithmetic is modulo 2^PC_WIDTH, so 0xFF+1 = 0x00 with no flag.
- `rst` has top priority in every state, including mid-stall and mid-branch.

## Timing
- Rising-edge registers only; no combinational path from `imem_data` to any output.
- Reset release latency: the first cycle with `rst`=0 is cycle 0. `instr_valid`=1 in cycle 2 with `pc_out`=`RESET_PC`.
- Throughput: one instruction per cycle when `stall`=0.
- Branch penalty: exactly one bubble cycle (`instr_valid`=0). The target instruction is valid 2 cycles after the branch accept edge.
- Stall: outputs stable for the whole stall. The next instruction is valid in the cycle after `stall` falls.
- Sustained stall for N cycles loses no instruction and duplicates none.

## Test plan
- Reset/sequential: ROM[0..3]=0x0123, 0x0003, 0x3456, 0x4A07, with `rst` pulsed one cycle -> cycles 2..5 show `instr` = 0x0123, 0x0003, 0x3456, 0x4A07. The first two give `opcode`=0 with `FnCode`=3 and 3; then `opcode`=3, then `opcode`=4. `pc_out` runs 0..3 and `instr_count` reaches 4.
- Stall: assert `stall` for 3 cycles while `pc_out`=1 -> `instr`=0x0003 held for 4 cycles. The next valid is `pc_out`=2, `instr`=0x3456, with no skip or duplicate.
- Branch: `branch_taken`=1 with `branch_target`=0x40 while `pc_out`=2 -> one cycle with `instr_valid`=0. Then `pc_out`=0x40 and `instr`=ROM[0x40], then 0x41.
- Branch under stall: `branch_taken`=1 with `stall`=1 -> ignored. Sequential order continues after the stall.
- Halt: ROM[4]=0xF000 -> `halted`=1 one cycle after it is presented. `instr_valid` stays 0 and `imem_addr` stays constant for 20 cycles. A `rst` pulse then restarts from ROM[0].
- Wrap: `branch_target`=0xFE -> `pc_out` sequence 0xFE, 0xFF, 0x00, 0x01.
- Mid-stall reset: `rst` asserted during a stall -> the reset values listed under Operation are present in the cycle after the reset edge.
